// File: rtl/cc_loader.sv
// Six-nibble frame loader: collects operand nibbles plus opt/equ into a held frame for the compute stage.
// Optional idle-timeout abort with a frame_err pulse is compiled in when CC_LOADER_TIMEOUT_EN is defined.
module cc_loader #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  input  logic [2:0] in_opt,
  input  logic       in_equ,
  output logic       in_ready,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_n0,
  output logic [3:0] out_n1,
  output logic [3:0] out_n2,
  output logic [3:0] out_n3,
  output logic [3:0] out_n4,
  output logic [3:0] out_n5,
  output logic [2:0] out_opt,
  output logic       out_equ,
  output logic       frame_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_HOLD} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_slot [6];
  logic [2:0] r_count;
  logic [2:0] r_opt;
  logic       r_equ;
  logic       w_accept;
  logic       w_timeout;

  assign in_ready  = (r_state != ST_HOLD);
  assign out_valid = (r_state == ST_HOLD);
  assign w_accept  = in_valid && in_ready;

`ifdef CC_LOADER_TIMEOUT_EN
  logic [4:0] r_idle_cnt;
  logic       r_frame_err;

  // Abort when this idle cycle would bring the counter to TIMEOUT_CYC; an accept always wins.
  assign w_timeout = (r_state == ST_LOAD) && !w_accept
                     && (r_idle_cnt == 5'(TIMEOUT_CYC - 1));
  assign frame_err = r_frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle_cnt  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_timeout;
      if (r_state != ST_LOAD || w_accept || w_timeout) r_idle_cnt <= '0;
      else                                             r_idle_cnt <= r_idle_cnt + 5'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
  // frame_err is constant 0 here; the term only keeps TIMEOUT_CYC referenced.
  assign frame_err = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_LOAD;
      ST_LOAD: begin
        if (w_timeout)                      w_next = ST_IDLE;
        else if (w_accept && r_count == 3'd5) w_next = ST_HOLD;
      end
      ST_HOLD: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: the slot array is reset explicitly because the outputs must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) r_slot[i] <= '0;
      r_count <= '0;
      r_opt   <= '0;
      r_equ   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_slot[0] <= in_data;
          r_opt     <= in_opt;
          r_equ     <= in_equ;
          r_count   <= 3'd1;
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_slot[r_count] <= in_data;
            r_count         <= (r_count == 3'd5) ? 3'd0 : r_count + 3'd1;
          end else if (w_timeout) begin
            r_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_n0  = r_slot[0];
  assign out_n1  = r_slot[1];
  assign out_n2  = r_slot[2];
  assign out_n3  = r_slot[3];
  assign out_n4  = r_slot[4];
  assign out_n5  = r_slot[5];
  assign out_opt = r_opt;
  assign out_equ = r_equ;

endmodule

// File: tb/tb_cc_loader.sv
// Scoreboard bench for cc_loader: stimulus queues expected frames, a negedge monitor checks each presented frame.
// Timeout scenarios run only when CC_LOADER_TIMEOUT_EN is defined.
module tb_cc_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic [2:0] in_opt = '0;
  logic       in_equ = 1'b0;
  logic       in_ready;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] out_n0, out_n1, out_n2, out_n3, out_n4, out_n5;
  logic [2:0] out_opt;
  logic       out_equ;
  logic       frame_err;

  always #5 clk = ~clk;

  cc_loader #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_opt(in_opt), .in_equ(in_equ),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
    .out_n0(out_n0), .out_n1(out_n1), .out_n2(out_n2),
    .out_n3(out_n3), .out_n4(out_n4), .out_n5(out_n5),
    .out_opt(out_opt), .out_equ(out_equ), .frame_err(frame_err)
  );

  typedef struct packed {
    logic [5:0][3:0] n;
    logic [2:0]      opt;
    logic            equ;
  } frame_t;

  frame_t exp_q[$];
  frame_t cur;
  frame_t act_fr;
  int     n_checks = 0;
  int     n_fail = 0;
  int     err_pulses = 0;
  int     frames_seen = 0;
  logic   prev_valid = 1'b0;

  assign act_fr = {out_n5, out_n4, out_n3, out_n2, out_n1, out_n0, out_opt, out_equ};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input logic [3:0] a, b, c, d, e, f,
                                input logic [2:0] o, input logic q);
    frame_t fr;
    fr.n[0] = a; fr.n[1] = b; fr.n[2] = c;
    fr.n[3] = d; fr.n[4] = e; fr.n[5] = f;
    fr.opt = o;
    fr.equ = q;
    return fr;
  endfunction

  // Monitor: pops on the first cycle a frame is presented, then checks it stays stable while held.
  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (!rst && out_valid) begin
      if (!prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got 0x%0h, expected no frame", act_fr);
        end else begin
          cur = exp_q.pop_front();
          check("frame", 32'(act_fr), 32'(cur));
          frames_seen++;
        end
      end else begin
        check("hold_stable", 32'(act_fr), 32'(cur));
      end
    end
    prev_valid = out_valid && !rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic [2:0] o, input logic e);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_opt   = o;
    in_equ   = e;
    t = 0;
    while (!in_ready && t < 40) begin
      tick();
      t++;
    end
    if (t >= 40) check("send_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int gap,
                            input logic [2:0] later_opt, input logic later_equ);
    exp_q.push_back(f);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) send(f.n[i], f.opt, f.equ);
      else        send(f.n[i], later_opt, later_equ);
      repeat (gap) tick();
    end
  endtask

  task automatic wait_valid(input string name);
    int t;
    t = 0;
    while (!out_valid && t < 40) begin
      tick();
      t++;
    end
    check(name, 32'(out_valid), 32'd1);
  endtask

  task automatic drain(input int hold);
    out_ready = 1'b0;
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    check("release_valid_low", 32'(out_valid), 32'd0);
    check("release_ready_high", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int exp_frames;
    int exp_err;
    frame_t f_a;
    exp_frames = 0;
    exp_err = 0;
    f_a = mk(4'h3, 4'hF, 4'h7, 4'h0, 4'h8, 4'h2, 3'b101, 1'b1);

    repeat (2) tick();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_outputs", 32'(act_fr), 32'd0);
    rst = 1'b0;
    tick();

    // Back-to-back frame: out_valid must be up right after the 6th accept edge.
    send_frame(f_a, 0, 3'b101, 1'b1);
    exp_frames++;
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_ready", 32'(in_ready), 32'd0);

    // Long hold with noisy input: nothing accepted, outputs stable (monitor).
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i + 5);
      in_opt   = 3'(i);
      in_equ   = i[0];
      check("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    drain(0);

    // opt/equ changing after the first nibble must be ignored.
    send_frame(mk(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 3'd2, 1'b1), 0, 3'd7, 1'b0);
    exp_frames++;
    wait_valid("opt_frame_valid");
    drain(2);

    // Three idle cycles between nibbles give the same frame.
    send_frame(f_a, 3, 3'b101, 1'b1);
    exp_frames++;
    wait_valid("gap_frame_valid");
    check("gap_no_err", 32'(err_pulses), 32'd0);
    drain(0);

    // Reset after 4 accepts discards the partial frame silently.
    for (int i = 0; i < 4; i++) send(4'h9, 3'd6, 1'b1);
    rst = 1'b1;
    tick();
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_n0", 32'(out_n0), 32'd0);
    rst = 1'b0;
    send_frame(mk(4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h1, 3'd4, 1'b0), 0, 3'd4, 1'b0);
    exp_frames++;
    wait_valid("fresh_frame_valid");
    drain(1);

    // Continuous traffic with out_ready high: the HOLD cycle stalls input, both frames intact.
    out_ready = 1'b1;
    send_frame(mk(4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 3'd3, 1'b0), 0, 3'd3, 1'b0);
    send_frame(mk(4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 3'd1, 1'b1), 0, 3'd1, 1'b1);
    exp_frames += 2;
    repeat (3) tick();
    out_ready = 1'b0;
    check("streaming_frames", 32'(frames_seen), 32'(exp_frames));

`ifdef CC_LOADER_TIMEOUT_EN
    // 2 accepts then 16 idle cycles: one frame_err pulse and back to IDLE.
    send(4'h4, 3'd2, 1'b0);
    send(4'h4, 3'd2, 1'b0);
    repeat (16) tick();
    repeat (3) tick();
    exp_err++;
    check("timeout_pulse", 32'(err_pulses), 32'(exp_err));
    check("timeout_in_ready", 32'(in_ready), 32'd1);
    send_frame(mk(4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 3'd5, 1'b1), 0, 3'd5, 1'b1);
    exp_frames++;
    wait_valid("post_timeout_valid");
    drain(0);

    // Accept landing on the 16th idle cycle wins over the timeout.
    exp_q.push_back(mk(4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 3'd6, 1'b0));
    send(4'h8, 3'd6, 1'b0);
    send(4'h9, 3'd6, 1'b0);
    repeat (15) tick();
    send(4'hA, 3'd6, 1'b0);
    send(4'hB, 3'd6, 1'b0);
    send(4'hC, 3'd6, 1'b0);
    send(4'hD, 3'd6, 1'b0);
    exp_frames++;
    wait_valid("late_accept_valid");
    check("late_accept_no_err", 32'(err_pulses), 32'(exp_err));
    drain(0);
`endif

    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("frames_seen", 32'(frames_seen), 32'(exp_frames));
    check("err_pulses", 32'(err_pulses), 32'(exp_err));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
